// File: rtl/snes_mem_seq_pkg.sv
// rtl/snes_mem_seq_pkg.sv - shared types and constants for the SNES/MCU memory sequencer
package snes_mem_seq_pkg;

  localparam int unsigned ACCESS_CYCLES_MIN = 2;
  localparam int unsigned ACCESS_CYCLES_MAX = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SNES_RD = 3'd1,
    SNES_WR = 3'd2,
    MCU_RD  = 3'd3,
    MCU_WR  = 3'd4
  } state_e;

  // Timer reload value (N-1); out-of-range lengths are clamped into the 4-bit counter.
  function automatic logic [3:0] timer_load(input int unsigned n);
    int unsigned c;
    c = n;
    if (c < ACCESS_CYCLES_MIN) c = ACCESS_CYCLES_MIN;
    if (c > ACCESS_CYCLES_MAX) c = ACCESS_CYCLES_MAX;
    return 4'(c - 1);
  endfunction

endpackage

// File: rtl/snes_mem_seq_if.sv
// rtl/snes_mem_seq_if.sv - SNES, MCU and memory-bus signal bundle for the sequencer
interface snes_mem_seq_if;

  logic        snes_req;
  logic        snes_we;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_wrdata;
  logic [7:0]  snes_rddata;
  logic        snes_rd_valid;
  logic        snes_overrun;

  logic        mcu_req;
  logic        mcu_we;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wrdata;
  logic        mcu_ack;
  logic [7:0]  mcu_rddata;

  logic [23:0] mem_addr;
  logic [7:0]  mem_dq_in;
  logic [7:0]  mem_dq_out;
  logic        mem_dq_oe;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  modport master (
    output snes_req, snes_we, rom_addr, rom_hit, is_writable, snes_wrdata,
    input  snes_rddata, snes_rd_valid, snes_overrun,
    output mcu_req, mcu_we, mcu_addr, mcu_wrdata,
    input  mcu_ack, mcu_rddata,
    input  mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n,
    output mem_dq_in
  );

  modport slave (
    input  snes_req, snes_we, rom_addr, rom_hit, is_writable, snes_wrdata,
    output snes_rddata, snes_rd_valid, snes_overrun,
    input  mcu_req, mcu_we, mcu_addr, mcu_wrdata,
    output mcu_ack, mcu_rddata,
    output mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n,
    input  mem_dq_in
  );

endinterface

// File: rtl/snes_mem_seq.sv
// rtl/snes_mem_seq.sv - arbitrates SNES and MCU accesses onto one async SRAM-style memory
// SNES has priority; its requests are buffered in a one-entry slot where the latest wins.
module snes_mem_seq
  import snes_mem_seq_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  snes_mem_seq_if.slave bus
);

  localparam logic [3:0] LOAD = timer_load(ACCESS_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_we_q, pend_we_d;
  logic [23:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dq_out_q, mem_dq_out_d;
  logic [7:0]  snes_rddata_q, snes_rddata_d;
  logic        snes_rd_valid_q, snes_rd_valid_d;
  logic [7:0]  mcu_rddata_q, mcu_rddata_d;
  logic        mcu_ack_q, mcu_ack_d;
  logic        mcu_guard_q, mcu_guard_d;
  logic        overrun_q, overrun_d;

  logic        snes_take;
  logic        snes_ready;
  logic        mcu_blocked;
  logic        start_access;
  logic        sel_we;
  logic [23:0] sel_addr;
  logic [7:0]  sel_data;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe;

  assign snes_take   = bus.snes_req && bus.rom_hit && (!bus.snes_we || bus.is_writable);
  assign snes_ready  = pend_valid_q || snes_take;
  // MCU_REQ is a level held until it sees the ack, so it is masked in the ack cycle and the one after.
  assign mcu_blocked = mcu_ack_q || mcu_guard_q;

  // A request arriving this cycle is newer than the slot contents.
  assign sel_we   = snes_take ? bus.snes_we     : pend_we_q;
  assign sel_addr = snes_take ? bus.rom_addr    : pend_addr_q;
  assign sel_data = snes_take ? bus.snes_wrdata : pend_data_q;

  assign start_access = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (snes_ready) begin
          state_d = sel_we ? SNES_WR : SNES_RD;
        end else if (bus.mcu_req && !mcu_blocked) begin
          state_d = bus.mcu_we ? MCU_WR : MCU_RD;
        end
      end
      default: begin
        if (cnt_q == 4'd0) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_ce_n  = 1'b1;
    mem_oe_n  = 1'b1;
    mem_we_n  = 1'b1;
    mem_dq_oe = 1'b0;
    unique case (state_q)
      SNES_RD, MCU_RD: begin
        mem_ce_n = 1'b0;
        mem_oe_n = 1'b0;
      end
      SNES_WR, MCU_WR: begin
        mem_ce_n  = 1'b0;
        mem_dq_oe = 1'b1;
        // WE_N rises one cycle before the end so data is held past the strobe.
        mem_we_n  = (cnt_q == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_dq_out_d = mem_dq_out_q;
    pend_valid_d = pend_valid_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    overrun_d    = overrun_q;

    if (start_access) begin
      cnt_d = LOAD;
      if (snes_ready) begin
        mem_addr_d   = sel_addr;
        mem_dq_out_d = sel_data;
      end else begin
        mem_addr_d   = bus.mcu_addr;
        mem_dq_out_d = bus.mcu_wrdata;
      end
    end else if (state_q != IDLE && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    if (state_q == IDLE) begin
      if (snes_ready) pend_valid_d = 1'b0;
    end else if (snes_take) begin
      pend_valid_d = 1'b1;
      pend_we_d    = bus.snes_we;
      pend_addr_d  = bus.rom_addr;
      pend_data_d  = bus.snes_wrdata;
    end

    if (snes_take && pend_valid_q) overrun_d = 1'b1;
  end

  always_comb begin
    snes_rd_valid_d = (state_q == SNES_RD) && (cnt_q == 4'd0);
    snes_rddata_d   = snes_rd_valid_d ? bus.mem_dq_in : snes_rddata_q;
    mcu_ack_d       = (state_q == MCU_RD || state_q == MCU_WR) && (cnt_q == 4'd0);
    mcu_rddata_d    = (state_q == MCU_RD && cnt_q == 4'd0) ? bus.mem_dq_in : mcu_rddata_q;
    mcu_guard_d     = mcu_ack_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q           <= 4'd0;
      pend_valid_q    <= 1'b0;
      pend_we_q       <= 1'b0;
      pend_addr_q     <= 24'd0;
      pend_data_q     <= 8'd0;
      mem_addr_q      <= 24'd0;
      mem_dq_out_q    <= 8'd0;
      snes_rddata_q   <= 8'd0;
      snes_rd_valid_q <= 1'b0;
      mcu_rddata_q    <= 8'd0;
      mcu_ack_q       <= 1'b0;
      mcu_guard_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      pend_valid_q    <= pend_valid_d;
      pend_we_q       <= pend_we_d;
      pend_addr_q     <= pend_addr_d;
      pend_data_q     <= pend_data_d;
      mem_addr_q      <= mem_addr_d;
      mem_dq_out_q    <= mem_dq_out_d;
      snes_rddata_q   <= snes_rddata_d;
      snes_rd_valid_q <= snes_rd_valid_d;
      mcu_rddata_q    <= mcu_rddata_d;
      mcu_ack_q       <= mcu_ack_d;
      mcu_guard_q     <= mcu_guard_d;
      overrun_q       <= overrun_d;
    end
  end

  assign bus.mem_ce_n      = mem_ce_n;
  assign bus.mem_oe_n      = mem_oe_n;
  assign bus.mem_we_n      = mem_we_n;
  assign bus.mem_dq_oe     = mem_dq_oe;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_dq_out    = mem_dq_out_q;
  assign bus.snes_rddata   = snes_rddata_q;
  assign bus.snes_rd_valid = snes_rd_valid_q;
  assign bus.snes_overrun  = overrun_q;
  assign bus.mcu_ack       = mcu_ack_q;
  assign bus.mcu_rddata    = mcu_rddata_q;

endmodule

// File: tb/tb_snes_mem_seq.sv
// tb/tb_snes_mem_seq.sv - scoreboard bench for snes_mem_seq with directed vectors
module tb_snes_mem_seq;
  import snes_mem_seq_pkg::*;

  localparam int N = 4;

  typedef struct {
    int          start;
    logic        we;
    logic [23:0] addr;
    logic [7:0]  data;
    int          len;
  } acc_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  acc_t  acc_q[$];
  resp_t snes_q[$];
  resp_t mcu_q[$];

  snes_mem_seq_if bus();

  snes_mem_seq #(.ACCESS_CYCLES(N)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Memory model: read data is a fixed function of the address.
  assign bus.mem_dq_in = bus.mem_addr[7:0] ^ 8'h5A;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snes_pulse(input logic we, input logic [23:0] addr, input logic [7:0] data,
                            input logic hit, input logic wr_ok);
    bus.snes_req    = 1'b1;
    bus.snes_we     = we;
    bus.rom_addr    = addr;
    bus.snes_wrdata = data;
    bus.rom_hit     = hit;
    bus.is_writable = wr_ok;
    tick();
    bus.snes_req    = 1'b0;
  endtask

  task automatic mcu_start(input logic we, input logic [23:0] addr, input logic [7:0] data);
    bus.mcu_req    = 1'b1;
    bus.mcu_we     = we;
    bus.mcu_addr   = addr;
    bus.mcu_wrdata = data;
  endtask

  task automatic wait_ack(input int hold);
    int k;
    k = 0;
    while (!bus.mcu_ack && k < 60) begin
      tick();
      k++;
    end
    if (!bus.mcu_ack) chk("mcu_ack_timeout", bus.mcu_ack, 1);
    repeat (hold) tick();
    bus.mcu_req = 1'b0;
  endtask

  function automatic acc_t mk_acc(input int s, input logic we, input logic [23:0] a,
                                  input logic [7:0] d, input int len);
    acc_t x;
    x.start = s; x.we = we; x.addr = a; x.data = d; x.len = len;
    return x;
  endfunction

  function automatic resp_t mk_resp(input int c, input logic [7:0] d);
    resp_t x;
    x.cyc = c; x.data = d;
    return x;
  endfunction

  // Monitor: reconstructs each memory access from the strobes and scores completion pulses.
  initial begin
    bit          in_acc;
    int          a_start, a_len, a_welow, a_oelow;
    logic        a_we, a_stable, a_last_we_n;
    logic [23:0] a_addr;
    logic [7:0]  a_data;
    acc_t        ea;
    resp_t       er;
    in_acc = 0;
    forever begin
      @(negedge clk);
      if (!bus.mem_ce_n) begin
        if (!in_acc) begin
          in_acc = 1; a_start = cyc; a_addr = bus.mem_addr; a_data = bus.mem_dq_out;
          a_we = bus.mem_dq_oe; a_len = 0; a_welow = 0; a_oelow = 0; a_stable = 1'b1;
        end
        a_len++;
        if (!bus.mem_we_n) a_welow++;
        if (!bus.mem_oe_n) a_oelow++;
        if (bus.mem_addr !== a_addr || bus.mem_dq_out !== a_data || bus.mem_dq_oe !== a_we)
          a_stable = 1'b0;
        a_last_we_n = bus.mem_we_n;
      end else if (in_acc) begin
        in_acc = 0;
        if (acc_q.size() == 0) begin
          chk("acc_unexpected_len", a_len, 0);
        end else begin
          ea = acc_q.pop_front();
          chk("acc_start", a_start, ea.start);
          chk("acc_len", a_len, ea.len);
          chk("acc_we", a_we, ea.we);
          chk("acc_addr", a_addr, ea.addr);
          chk("acc_stable", a_stable, 1);
          if (ea.we) begin
            chk("acc_wdata", a_data, ea.data);
            chk("acc_we_low_cycles", a_welow, ea.len - 1);
            chk("acc_we_n_last", a_last_we_n, 1);
          end else begin
            chk("acc_oe_low_cycles", a_oelow, ea.len);
            chk("acc_rd_we_low", a_welow, 0);
          end
        end
      end

      if (bus.snes_rd_valid) begin
        if (snes_q.size() == 0) chk("snes_rd_valid_unexpected", bus.snes_rd_valid, 0);
        else begin
          er = snes_q.pop_front();
          chk("snes_rd_cycle", cyc, er.cyc);
          chk("snes_rddata", bus.snes_rddata, er.data);
        end
      end

      if (bus.mcu_ack) begin
        if (mcu_q.size() == 0) chk("mcu_ack_unexpected", bus.mcu_ack, 0);
        else begin
          er = mcu_q.pop_front();
          chk("mcu_ack_cycle", cyc, er.cyc);
          chk("mcu_rddata", bus.mcu_rddata, er.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.snes_req = 0; bus.snes_we = 0; bus.rom_addr = 0; bus.rom_hit = 0;
    bus.is_writable = 0; bus.snes_wrdata = 0;
    bus.mcu_req = 0; bus.mcu_we = 0; bus.mcu_addr = 0; bus.mcu_wrdata = 0;

    repeat (3) tick();
    chk("rst_ce_n", bus.mem_ce_n, 1);
    chk("rst_oe_n", bus.mem_oe_n, 1);
    chk("rst_we_n", bus.mem_we_n, 1);
    chk("rst_dq_oe", bus.mem_dq_oe, 0);
    chk("rst_rd_valid", bus.snes_rd_valid, 0);
    chk("rst_mcu_ack", bus.mcu_ack, 0);
    chk("rst_overrun", bus.snes_overrun, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // SNES read hit, 0xFF ^ 0x5A = 0xA5
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b0, 24'h0000FF, 8'h00, N));
    snes_q.push_back(mk_resp(t + N + 1, 8'hA5));
    snes_pulse(1'b0, 24'h0000FF, 8'h00, 1'b1, 1'b0);
    repeat (8) tick();

    // Dropped requests: write to non-writable target, read that misses cartridge memory
    snes_pulse(1'b1, 24'h300000, 8'h11, 1'b1, 1'b0);
    repeat (6) tick();
    snes_pulse(1'b0, 24'h300001, 8'h00, 1'b0, 1'b1);
    repeat (6) tick();

    // SNES write to writable target
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b1, 24'h200000, 8'h3C, N));
    snes_pulse(1'b1, 24'h200000, 8'h3C, 1'b1, 1'b1);
    repeat (8) tick();

    // Same-cycle SNES read and MCU read: SNES first, MCU ack at t+2N+2
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b0, 24'h000011, 8'h00, N));
    snes_q.push_back(mk_resp(t + N + 1, 8'h4B));
    acc_q.push_back(mk_acc(t + N + 2, 1'b0, 24'h0000F0, 8'h00, N));
    mcu_q.push_back(mk_resp(t + 2 * N + 2, 8'hAA));
    mcu_start(1'b0, 24'h0000F0, 8'h00);
    snes_pulse(1'b0, 24'h000011, 8'h00, 1'b1, 1'b0);
    wait_ack(0);
    repeat (4) tick();

    // Two SNES requests during an MCU write: only the second runs, overrun sets
    chk("overrun_before", bus.snes_overrun, 0);
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b1, 24'h123456, 8'h77, N));
    mcu_q.push_back(mk_resp(t + N + 1, 8'hAA));
    acc_q.push_back(mk_acc(t + N + 2, 1'b0, 24'h000030, 8'h00, N));
    snes_q.push_back(mk_resp(t + 2 * N + 2, 8'h6A));
    mcu_start(1'b1, 24'h123456, 8'h77);
    tick();
    snes_pulse(1'b0, 24'h000020, 8'h00, 1'b1, 1'b0);
    snes_pulse(1'b0, 24'h000030, 8'h00, 1'b1, 1'b0);
    wait_ack(0);
    repeat (8) tick();
    chk("overrun_after", bus.snes_overrun, 1);

    // MCU write with request held one cycle past ack: exactly one access
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b1, 24'h123456, 8'h9C, N));
    mcu_q.push_back(mk_resp(t + N + 1, 8'hAA));
    mcu_start(1'b1, 24'h123456, 8'h9C);
    wait_ack(1);
    repeat (10) tick();

    // Reset in access cycle 2: immediate strobe release, no completion
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b0, 24'h000040, 8'h00, 1));
    snes_pulse(1'b0, 24'h000040, 8'h00, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ce_n", bus.mem_ce_n, 1);
    chk("midrst_oe_n", bus.mem_oe_n, 1);
    chk("midrst_dq_oe", bus.mem_dq_oe, 0);
    chk("midrst_overrun", bus.snes_overrun, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("postrst_rd_valid", bus.snes_rd_valid, 0);
    repeat (6) tick();

    // SNES read after reset: 0x50 ^ 0x5A = 0x0A
    t = cyc;
    acc_q.push_back(mk_acc(t + 1, 1'b0, 24'h000050, 8'h00, N));
    snes_q.push_back(mk_resp(t + N + 1, 8'h0A));
    snes_pulse(1'b0, 24'h000050, 8'h00, 1'b1, 1'b0);
    repeat (10) tick();

    chk("acc_q_drained", acc_q.size(), 0);
    chk("snes_q_drained", snes_q.size(), 0);
    chk("mcu_q_drained", mcu_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_mem_seq.md
SNES_MEM_SEQ -- requirements
Module: snes_mem_seq

Interface
REQ-001 Parameter ACCESS_CYCLES, default 4, sets the memory access length in CLK cycles; legal range 2..15.
REQ-002 CLK  in  1  system clock; all state is on the rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 SNES_REQ  in  1  one-cycle pulse: SNES bus cycle start, address already decoded.
REQ-005 SNES_WE  in  1  high means the SNES cycle is a write.
REQ-006 ROM_ADDR  in  24  translated memory address from the address decoder.
REQ-007 ROM_HIT  in  1  the cycle targets cartridge memory.
REQ-008 IS_WRITABLE  in  1  the target accepts writes (SaveRAM or PSRAM).
REQ-009 SNES_WRDATA  in  8  SNES write data, valid with SNES_REQ.
REQ-010 SNES_RDDATA  out  8  SNES read data.
REQ-011 SNES_RD_VALID  out  1  one-cycle pulse: SNES_RDDATA is valid.
REQ-012 SNES_OVERRUN  out  1  sticky flag: a pending SNES request was overwritten.
REQ-013 MCU_REQ  in  1  level request; held until MCU_ACK.
REQ-014 MCU_WE  in  1  MCU write when high.
REQ-015 MCU_ADDR  in  24  MCU target address.
REQ-016 MCU_WRDATA  in  8  MCU write data.
REQ-017 MCU_ACK  out  1  one-cycle pulse: MCU access complete.
REQ-018 MCU_RDDATA  out  8  MCU read data, valid with MCU_ACK and held afterwards.
REQ-019 MEM_ADDR  out  24  memory address.
REQ-020 MEM_DQ_IN  in  8  memory read data.
REQ-021 MEM_DQ_OUT  out  8  memory write data.
REQ-022 MEM_DQ_OE  out  1  FPGA drives the data bus.
REQ-023 MEM_CE_N, MEM_OE_N, MEM_WE_N  out  1 each  memory strobes, active-low.

Function
REQ-024 States SHALL be IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR.
REQ-025 SNES_REQ SHALL be latched into a one-entry pending slot holding address, WE and data, but only when ROM_HIT=1 and (SNES_WE=0 or IS_WRITABLE=1); other requests are dropped with no memory activity.
REQ-026 A latched SNES_REQ while the slot is already full SHALL overwrite the slot (latest request wins) and set SNES_OVERRUN.
REQ-027 Arbitration in IDLE, on a full slot or a latching SNES_REQ:
- the SNES access SHALL win, including same-cycle contention with MCU_REQ.
- otherwise MCU_REQ=1 starts an MCU access.
REQ-028 An SNES_REQ latched in IDLE at cycle t SHALL produce access cycles t+1..t+N, where N=ACCESS_CYCLES.
REQ-029 Timer behaviour:
- a 4-bit down-counter SHALL be loaded with N-1 on access entry.
- the access SHALL end when the counter reaches 0.
- the FSM SHALL return to IDLE on the following cycle.
REQ-030 During any access, MEM_CE_N SHALL be 0.
REQ-031 During a read access, MEM_OE_N SHALL be 0.
REQ-032 During a write access:
- MEM_DQ_OE SHALL be 1 for all N cycles.
- MEM_WE_N SHALL be 0 for cycles 1..N-1 and 1 in cycle N (data hold).
REQ-033 MEM_ADDR and MEM_DQ_OUT SHALL be registered at access entry and held constant for the whole access.
REQ-034 On reads, MEM_DQ_IN SHALL be captured at the edge ending cycle N, and SNES_RD_VALID or MCU_ACK SHALL pulse in cycle N+1 with the captured data.
REQ-035 MCU_ACK SHALL also pulse in cycle N+1 after an MCU write; SNES writes produce no completion pulse.
REQ-036 MCU_REQ SHALL be ignored in the cycle following MCU_ACK (one-cycle guard).
REQ-037 An SNES_REQ arriving during an MCU access SHALL be serviced in the cycle after that access returns to IDLE, ahead of MCU_REQ; worst-case SNES latency is 2N+2 cycles.
REQ-038 SNES_OVERRUN SHALL clear only on reset.

Reset
REQ-039 RST_N=0 SHALL immediately force:
- state IDLE;
- MEM_CE_N, MEM_OE_N and MEM_WE_N to 1;
- MEM_DQ_OE, SNES_RD_VALID, MCU_ACK and SNES_OVERRUN to 0;
- data and address registers to 0;
- the pending slot empty.
REQ-040 Reset asserted mid-access SHALL abort the access with no completion pulse.

Structure
REQ-041 A shared package SHALL hold the state enumeration and the ACCESS_CYCLES range constants.
REQ-042 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-043 N=4: SNES read hit at t=10, MEM_DQ_IN=8'hA5 → CE_N/OE_N low in cycles 11..14; SNES_RD_VALID at 15 with 8'hA5.
REQ-044 SNES write with IS_WRITABLE=0 → no strobes; with IS_WRITABLE=1 and data 8'h3C → WE_N low in cycles 1..3, MEM_DQ_OUT=8'h3C.
REQ-045 SNES_REQ and MCU_REQ in the same IDLE cycle → SNES access first; MCU_ACK at cycle 2N+2 after the request.
REQ-046 Two SNES_REQ during an MCU access → only the second is serviced; SNES_OVERRUN=1.
REQ-047 MCU write to 24'h123456, MCU_REQ held one cycle past MCU_ACK → exactly one access (guard works).
REQ-048 RST_N low in access cycle 2 → strobes high immediately, no SNES_RD_VALID, state IDLE after release.
